// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO responder: decodes management frames sampled on MDC and
// serves reads/writes through a single-cycle register strobe port.
module mdio_phy_slave #(
    parameter int PRE_LEN     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [4:0]  phy_addr,
    input  logic        mdc_in,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe_n,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        frame_err
);

    localparam int PW = $clog2(PRE_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ST1, OP, PHYAD, REGAD, RD_TA1, RD_TA2, RD_DATA, WR_TA, WR_DATA, SKIP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
    logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
    logic                   mdc_prev_q;
    logic [PW-1:0]          pre_cnt_q, pre_cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]            shift_q, shift_d;
    logic                   mdio_out_q, mdio_out_d;
    logic                   mdio_oe_n_q, mdio_oe_n_d;
    logic                   reg_rd_q, reg_rd_d;
    logic                   reg_wr_q, reg_wr_d;
    logic [4:0]             reg_addr_q, reg_addr_d;
    logic [15:0]            reg_wdata_q, reg_wdata_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;

    logic                   mdc_s, mdio_s, mdc_rise, mdc_fall;
    logic [SYNC_STAGES:0]   mdc_chain, mdio_chain;
    logic [4:0]             hdr_phyad, hdr_regad;
    logic [1:0]             hdr_op;

    always_comb begin
        mdc_chain   = {mdc_sync_q, mdc_in};
        mdio_chain  = {mdio_sync_q, mdio_in};
        mdc_sync_d  = mdc_chain[SYNC_STAGES-1:0];
        mdio_sync_d = mdio_chain[SYNC_STAGES-1:0];
        mdc_s       = mdc_sync_q[SYNC_STAGES-1];
        mdio_s      = mdio_sync_q[SYNC_STAGES-1];
        mdc_rise    = mdc_s & ~mdc_prev_q;
        mdc_fall    = ~mdc_s & mdc_prev_q;
    end

    // Header bits accumulate in shift_q; the final REGAD bit comes straight from the pad.
    assign hdr_op    = shift_q[10:9];
    assign hdr_phyad = shift_q[8:4];
    assign hdr_regad = {shift_q[3:0], mdio_s};

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = '0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        mdio_out_d  = mdio_out_q;
        mdio_oe_n_d = mdio_oe_n_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                pre_cnt_d = pre_cnt_q;
                if (mdc_rise) begin
                    if (mdio_s) begin
                        if (pre_cnt_q != PW'(PRE_LEN)) pre_cnt_d = pre_cnt_q + 1'b1;
                    end else begin
                        pre_cnt_d = '0;
                        if (pre_cnt_q == PW'(PRE_LEN)) state_d = ST1;
                    end
                end
            end
            ST1: if (mdc_rise) begin
                bit_cnt_d = '0;
                if (mdio_s) begin
                    state_d = OP;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            OP, PHYAD: if (mdc_rise) begin
                shift_d   = {shift_q[14:0], mdio_s};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (state_q == OP && bit_cnt_q == 5'd1) begin
                    state_d   = PHYAD;
                    bit_cnt_d = '0;
                end else if (state_q == PHYAD && bit_cnt_q == 5'd4) begin
                    state_d   = REGAD;
                    bit_cnt_d = '0;
                end
            end
            REGAD: if (mdc_rise) begin
                shift_d   = {shift_q[14:0], mdio_s};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd4) begin
                    bit_cnt_d = 5'd18;
                    state_d   = SKIP;
                    if (hdr_phyad == phy_addr) begin
                        case (hdr_op)
                            2'b10: begin
                                state_d    = RD_TA1;
                                reg_addr_d = hdr_regad;
                                reg_rd_d   = 1'b1;
                            end
                            2'b01: begin
                                state_d    = WR_TA;
                                reg_addr_d = hdr_regad;
                                bit_cnt_d  = '0;
                            end
                            default: frame_err_d = 1'b1;
                        endcase
                    end
                end
            end
            RD_TA1: if (mdc_rise) state_d = RD_TA2;
            RD_TA2: begin
                if (mdc_fall) begin
                    mdio_oe_n_d = 1'b0;
                    mdio_out_d  = 1'b0;
                end
                if (mdc_rise) begin
                    state_d   = RD_DATA;
                    bit_cnt_d = '0;
                end
            end
            RD_DATA: if (mdc_fall) begin
                if (bit_cnt_q == 5'd16) begin
                    mdio_oe_n_d = 1'b1;
                    mdio_out_d  = 1'b0;
                    state_d     = IDLE;
                end else begin
                    mdio_out_d = shift_q[15];
                    shift_d    = {shift_q[14:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                end
            end
            WR_TA: if (mdc_rise) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd1) begin
                    state_d   = WR_DATA;
                    bit_cnt_d = '0;
                end
            end
            WR_DATA: if (mdc_rise) begin
                shift_d   = {shift_q[14:0], mdio_s};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd15) begin
                    reg_wdata_d = {shift_q[14:0], mdio_s};
                    reg_wr_d    = 1'b1;
                    state_d     = IDLE;
                end
            end
            SKIP: if (mdc_rise) begin
                bit_cnt_d = bit_cnt_q - 5'd1;
                if (bit_cnt_q == 5'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Read data is captured in the strobe cycle so the register port has a full cycle to respond.
        if (reg_rd_q) shift_d = reg_rdata;

        busy_d = (state_d != IDLE) && (state_d != ST1);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            mdc_prev_q  <= 1'b0;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            mdio_out_q  <= 1'b0;
            mdio_oe_n_q <= 1'b1;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            mdc_prev_q  <= mdc_s;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oe_n_q <= mdio_oe_n_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oe_n = mdio_oe_n_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Directed bench for mdio_phy_slave: a station-manager model clocks MDC at
// mclk/8 and the expected strobes and serial read data are hand-computed.
module tb_mdio_phy_slave;

   logic        mclk;
   logic        resetN;
   logic [4:0]  phyAddr;
   logic        mdc;
   logic        mdioIn;
   logic        mdioOut;
   logic        mdioOeN;
   logic        regRd;
   logic        regWr;
   logic [4:0]  regAddr;
   logic [15:0] regWdata;
   logic [15:0] regRdata;
   logic        busy;
   logic        frameErr;

   logic        masterEn;
   logic        masterVal;

   int assertCount;
   int failCount;
   int rdCount;
   int wrCount;
   int errCount;
   int bothCount;
   int oeLowCount;
   logic [4:0]  lastRdAddr;
   logic [4:0]  lastWrAddr;
   logic [15:0] lastWrData;

   mdio_phy_slave #(.PRE_LEN(32), .SYNC_STAGES(2)) dut (
      .mclk      (mclk),
      .reset_n   (resetN),
      .phy_addr  (phyAddr),
      .mdc_in    (mdc),
      .mdio_in   (mdioIn),
      .mdio_out  (mdioOut),
      .mdio_oe_n (mdioOeN),
      .reg_rd    (regRd),
      .reg_wr    (regWr),
      .reg_addr  (regAddr),
      .reg_wdata (regWdata),
      .reg_rdata (regRdata),
      .busy      (busy),
      .frame_err (frameErr)
   );

   // The shared pad: PHY wins when it drives, else the master or the pull-up.
   assign mdioIn = mdioOeN ? (masterEn ? masterVal : 1'b1) : mdioOut;

   // 100 MHz-style system clock, MDC is derived in the stimulus at mclk/8.
   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Passive monitor tallying strobes and pad activity on the falling mclk edge.
   always @(negedge mclk) begin
      if (regRd) begin
         rdCount++;
         lastRdAddr = regAddr;
      end
      if (regWr) begin
         wrCount++;
         lastWrAddr = regAddr;
         lastWrData = regWdata;
      end
      if (frameErr) errCount++;
      if (regRd && regWr) bothCount++;
      if (!mdioOeN) oeLowCount++;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One MDC bit: falling edge with new master data, rising edge, then hold
   // until just before the next fall so PHY responses have settled.
   task automatic applyStimulus(input logic b);
      #5;
      mdc       = 1'b0;
      masterVal = b;
      #40;
      mdc       = 1'b1;
      #35;
   endtask

   // Preamble of the given length, then start, opcode, PHY and register address.
   task automatic sendHeader(input int preLen, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regA);
      logic [13:0] hdr;
      hdr      = {2'b01, op, phy, regA};
      masterEn = 1'b1;
      for (int i = 0; i < preLen; i++) applyStimulus(1'b1);
      for (int i = 13; i >= 0; i--) applyStimulus(hdr[i]);
   endtask

   // Full read frame; checks turnaround, serial data and release when answered,
   // and pad silence plus no strobe when it must be ignored.
   task automatic readFrame(input int preLen, input logic [4:0] phy, input logic [4:0] regA,
                            input logic answered, input logic [15:0] data, input string tag);
      int rdBefore;
      int oeBefore;
      logic [15:0] rxWord;
      rdBefore = rdCount;
      oeBefore = oeLowCount;
      rxWord   = '0;
      sendHeader(preLen, 2'b10, phy, regA);
      masterEn = 1'b0;
      applyStimulus(1'b1);
      checkOutput({tag, " ta1 oe_n"}, 32'(mdioOeN), 32'd1);
      checkOutput({tag, " rd strobes"}, 32'(rdCount - rdBefore), answered ? 32'd1 : 32'd0);
      if (answered) checkOutput({tag, " rd addr"}, 32'(lastRdAddr), 32'(regA));
      applyStimulus(1'b1);
      checkOutput({tag, " ta2 oe_n"}, 32'(mdioOeN), answered ? 32'd0 : 32'd1);
      if (answered) checkOutput({tag, " ta2 out"}, 32'(mdioOut), 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1);
         rxWord = {rxWord[14:0], mdioOut};
      end
      if (answered) checkOutput({tag, " data"}, 32'(rxWord), 32'(data));
      applyStimulus(1'b1);
      checkOutput({tag, " release oe_n"}, 32'(mdioOeN), 32'd1);
      checkOutput({tag, " end busy"}, 32'(busy), 32'd0);
      if (!answered) checkOutput({tag, " pad silent"}, 32'(oeLowCount - oeBefore), 32'd0);
      masterEn = 1'b1;
   endtask

   // Full write frame; one strobe with the right address and data, pad untouched.
   task automatic writeFrame(input logic [4:0] regA, input logic [15:0] data, input string tag);
      int wrBefore;
      int rdBefore;
      int oeBefore;
      wrBefore = wrCount;
      rdBefore = rdCount;
      oeBefore = oeLowCount;
      sendHeader(32, 2'b01, phyAddr, regA);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      for (int i = 15; i >= 0; i--) applyStimulus(data[i]);
      checkOutput({tag, " wr strobes"}, 32'(wrCount - wrBefore), 32'd1);
      checkOutput({tag, " rd strobes"}, 32'(rdCount - rdBefore), 32'd0);
      checkOutput({tag, " wr addr"}, 32'(lastWrAddr), 32'(regA));
      checkOutput({tag, " wr data"}, 32'(lastWrData), 32'(data));
      checkOutput({tag, " reg_wdata"}, 32'(regWdata), 32'(data));
      checkOutput({tag, " pad silent"}, 32'(oeLowCount - oeBefore), 32'd0);
      checkOutput({tag, " end busy"}, 32'(busy), 32'd0);
   endtask

   // Directed sequence covering reset, write, read, address filter, preamble
   // length, framing errors and reset in the middle of a read.
   initial begin
      int rdBefore;
      int wrBefore;
      int errBefore;
      logic [7:0] partial;
      assertCount = 0;
      failCount   = 0;
      rdCount     = 0;
      wrCount     = 0;
      errCount    = 0;
      bothCount   = 0;
      oeLowCount  = 0;
      lastRdAddr  = '0;
      lastWrAddr  = '0;
      lastWrData  = '0;
      phyAddr     = 5'h03;
      regRdata    = 16'h1234;
      mdc         = 1'b1;
      masterEn    = 1'b1;
      masterVal   = 1'b1;
      resetN      = 1'b0;
      #23;
      resetN      = 1'b1;
      #20;

      checkOutput("rst mdio_out", 32'(mdioOut), 32'd0);
      checkOutput("rst mdio_oe_n", 32'(mdioOeN), 32'd1);
      checkOutput("rst reg_rd", 32'(regRd), 32'd0);
      checkOutput("rst reg_wr", 32'(regWr), 32'd0);
      checkOutput("rst reg_addr", 32'(regAddr), 32'd0);
      checkOutput("rst reg_wdata", 32'(regWdata), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst frame_err", 32'(frameErr), 32'd0);

      writeFrame(5'h0A, 16'hBEEF, "wr0A");

      regRdata = 16'h1234;
      readFrame(32, 5'h03, 5'h02, 1'b1, 16'h1234, "rd02");

      readFrame(32, 5'h07, 5'h02, 1'b0, 16'h0000, "rdMismatch");
      regRdata = 16'hA5C3;
      readFrame(32, 5'h03, 5'h11, 1'b1, 16'hA5C3, "rdAfterMismatch");

      regRdata = 16'h1234;
      applyStimulus(1'b0);
      readFrame(31, 5'h03, 5'h02, 1'b0, 16'h0000, "pre31");
      readFrame(32, 5'h03, 5'h02, 1'b1, 16'h1234, "pre32");

      rdBefore  = rdCount;
      wrBefore  = wrCount;
      errBefore = errCount;
      sendHeader(32, 2'b11, 5'h03, 5'h05);
      checkOutput("op11 frame_err", 32'(errCount - errBefore), 32'd1);
      for (int i = 0; i < 17; i++) applyStimulus(1'b1);
      checkOutput("op11 busy at 17", 32'(busy), 32'd1);
      applyStimulus(1'b1);
      checkOutput("op11 busy at 18", 32'(busy), 32'd0);
      checkOutput("op11 strobes", 32'((rdCount - rdBefore) + (wrCount - wrBefore)), 32'd0);

      errBefore = errCount;
      for (int i = 0; i < 32; i++) applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      checkOutput("start00 frame_err", 32'(errCount - errBefore), 32'd1);
      checkOutput("start00 busy", 32'(busy), 32'd0);

      regRdata = 16'h1234;
      partial  = '0;
      sendHeader(32, 2'b10, 5'h03, 5'h02);
      masterEn = 1'b0;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1);
         partial = {partial[6:0], mdioOut};
      end
      checkOutput("rst mid partial", 32'(partial), 32'h12);
      checkOutput("rst mid oe before", 32'(mdioOeN), 32'd0);
      resetN = 1'b0;
      #1;
      checkOutput("rst mid oe_n", 32'(mdioOeN), 32'd1);
      checkOutput("rst mid busy", 32'(busy), 32'd0);
      #39;
      resetN   = 1'b1;
      masterEn = 1'b1;
      readFrame(32, 5'h03, 5'h02, 1'b1, 16'h1234, "rdPostRst");

      checkOutput("rd and wr together", 32'(bothCount), 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mdio_phy_slave.md
Name: mdio_phy_slave

Overview:
- Clause-22 MDIO responder. It is the PHY-side counterpart of the MAC MDIO master that drives MDC/MDIO through the pinmux.
- Decodes management frames from an external or looped-back station manager and performs register reads/writes through a simple register port.
- Drives read data back on the shared MDIO pad.
- Used for PHY emulation, on-chip loopback verification of the MDIO master, and board-level bring-up.

Parameters:
- PRE_LEN, 32, number of consecutive preamble 1s required before a start-of-frame is accepted (legal range 1..32).
- SYNC_STAGES, 2, synchronizer depth applied to mdc_in and mdio_in.

Ports:
- mclk  in  1  system clock; must be at least 4x the MDC frequency.
- reset_n  in  1  asynchronous active-low reset.
- phy_addr  in  5  strapped PHY address.
- mdc_in  in  1  MDC from pad, asynchronous to mclk.
- mdio_in  in  1  MDIO pad input.
- mdio_out  out  1  MDIO pad output value.
- mdio_oe_n  out  1  MDIO pad output enable, active low (maps to io_oeb).
- reg_rd  out  1  one-mclk read strobe.
- reg_wr  out  1  one-mclk write strobe.
- reg_addr  out  5  register address; held stable from strobe until next frame.
- reg_wdata  out  16  write data; valid with reg_wr.
- reg_rdata  in  16  read data; sampled in the same mclk cycle as reg_rd.
- busy  out  1  high from start-bit detection until return to IDLE.
- frame_err  out  1  one-mclk pulse on an illegal opcode or a bad start bit.

Behaviour:
- Reset values: mdio_out=0, mdio_oe_n=1, reg_rd=0, reg_wr=0, reg_addr=0, reg_wdata=0, busy=0, frame_err=0. All state returns to IDLE and the preamble count to 0. Reset asserted mid-frame releases the pad asynchronously.
- Synchronization: mdc_in and mdio_in pass through SYNC_STAGES flops.
  - mdc_rise is a one-cycle pulse on a 0->1 of synchronized MDC; mdc_fall is a pulse on 1->0.
  - All sampling uses mdio_s at mdc_rise. All pad changes occur at mdc_fall.
- IDLE:
  - Count sampled 1s, saturating at PRE_LEN.
  - Sampled 0 with count==PRE_LEN -> ST1; sampled 0 with count<PRE_LEN -> count cleared, remain IDLE.
- ST1: sampled 1 -> OP, busy=1. Sampled 0 -> frame_err pulse, IDLE, count 0.
- OP: capture 2 bits, MSB first.
- PHYAD: capture 5 bits.
- REGAD: capture 5 bits. After the last bit, classify the frame:
  - Address mismatch (phyad != phy_addr) -> SKIP with 18 bits remaining.
  - op=2'b10 -> RD_TA1. reg_addr is updated; reg_rd pulses in the mclk cycle following the mdc_rise that sampled the last REGAD bit; reg_rdata is latched into the shift register in that same cycle.
  - op=2'b01 -> WR_TA with 2 bits.
  - op=2'b00 or op=2'b11 -> frame_err pulse, then SKIP with 18 bits.
- RD_TA1: pad stays released (Z) for the first TA bit.
- RD_TA2: at the mdc_fall following the rising edge that ends the TA1 bit time, mdio_oe_n=0 and mdio_out=0.
- RD_DATA: at each subsequent mdc_fall, drive shift[15] down to shift[0], MSB first. At the mdc_fall after the rising edge that completes D0, set mdio_oe_n=1 -> IDLE, busy=0.
- WR_TA: consume 2 bits, values ignored.
- WR_DATA: capture 16 bits, MSB first. In the mclk cycle after the 16th mdc_rise, reg_wdata is updated and reg_wr pulses. Then IDLE, busy=0.
- SKIP: count down one bit per mdc_rise; pad never driven; at zero -> IDLE.
- Preamble count is cleared on every frame exit, so each frame needs a fresh PRE_LEN preamble.
- reg_rd and reg_wr are never asserted in the same cycle, and at most one strobe is issued per frame.
- No timeout: a master abort mid-frame is recovered only by completing the bit count or by reset.

Test Plan:
- PRE_LEN=32, phy_addr=5'h03, MDC=mclk/8. Send a write frame with reg 5'h0A, data 16'hBEEF -> exactly one reg_wr pulse with reg_addr=0x0A and reg_wdata=0xBEEF; mdio_oe_n stays 1 throughout.
- Send a read frame with reg 5'h02 while reg_rdata=16'h1234 -> one reg_rd pulse with reg_addr=0x02. The pad is Z during TA1, drives 0 during TA2, then outputs the serial stream 0001_0010_0011_0100. Pad is released after D0 and busy falls.
- Read to phy_addr 5'h07 while strapped to 5'h03 -> no strobes, mdio_oe_n=1 for the whole frame; an immediately following valid read is answered.
- 31-bit preamble followed by a read frame -> ignored with no strobes. The same frame with 32 ones -> answered.
- Opcode 2'b11 -> one frame_err pulse, no strobes, return to IDLE after 18 further bits. Start pattern 00 after a full preamble -> frame_err pulse.
- Assert reset_n low during RD_DATA at bit 8 -> mdio_oe_n=1 immediately and busy=0. After release, a full read frame returns correct data.
